// File: rtl/lcd_bus_monitor_if.sv
// ============================================================================
// Module      : lcd_bus_monitor_if
// Description : 8-bit HD44780-style LCD write bus (data/rs/rw/en).
//               The master drives the bus; the monitor observes it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lcd_bus_monitor_if;
  logic [7:0] lcd_data_in;
  logic       lcd_rs_in;
  logic       lcd_rw_in;
  logic       lcd_en_in;

  modport master (
    output lcd_data_in,
    output lcd_rs_in,
    output lcd_rw_in,
    output lcd_en_in
  );

  modport slave (
    input lcd_data_in,
    input lcd_rs_in,
    input lcd_rw_in,
    input lcd_en_in
  );
endinterface

`default_nettype wire

// File: rtl/lcd_bus_monitor.sv
// ============================================================================
// Module      : lcd_bus_monitor
// Description : Receiving end of an HD44780-style LCD write bus. Decodes
//               enable strobes into commands/characters, keeps a 16x2 DDRAM
//               shadow, emulates busy timing and flags protocol violations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_bus_monitor #(
  parameter int SYNC_STAGES  = 2,
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  wire logic        clk_50,
  input  wire logic        rst_n,
  lcd_bus_monitor_if.slave bus,
  input  wire logic        err_clr,
  input  wire logic [4:0]  rd_addr,
  output logic      [7:0]  rd_data,
  output logic      [6:0]  cursor_addr,
  output logic             display_on,
  output logic             busy,
  output logic             cmd_valid,
  output logic             char_valid,
  output logic      [7:0]  code_out,
  output logic             protocol_err
);

  localparam int C_MAX   = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int C_CNT_W = $clog2(C_MAX + 1);
  localparam logic [C_CNT_W-1:0] C_BUSY_LD  = C_CNT_W'(BUSY_CYCLES);
  localparam logic [C_CNT_W-1:0] C_CLEAR_LD = C_CNT_W'(CLEAR_CYCLES);

  // Synchronizer chains; index SYNC_STAGES-1 is the settled stage
  logic [SYNC_STAGES-1:0][7:0] r_data_sync;
  logic [SYNC_STAGES-1:0]      r_rs_sync;
  logic [SYNC_STAGES-1:0]      r_rw_sync;
  logic [SYNC_STAGES-1:0]      r_en_sync;
  logic                        r_en_last;

  logic [7:0]         r_shadow [32];
  logic [6:0]         r_cursor;
  logic               r_id;
  logic               r_cgram;
  logic               r_disp;
  logic               r_busy;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_cmd_v;
  logic               r_char_v;
  logic [7:0]         r_code;
  logic               r_err;
  logic [7:0]         r_rd_data;

  logic       w_strobe, w_accept, w_violation;
  logic       w_rs, w_rw;
  logic [7:0] w_data;
  logic [6:0] w_cursor_nxt;
  logic       w_id_nxt, w_cgram_nxt, w_disp_nxt;
  logic       w_long, w_illegal, w_clear, w_wr_en;

  // Cursor step inside the two 16-byte lines, wrapping line to line
  function automatic logic [6:0] f_step(input logic [6:0] cur, input logic up);
    logic [6:0] v;
    if (up) begin
      if (cur == 7'h0F)      v = 7'h40;
      else if (cur == 7'h4F) v = 7'h00;
      else                   v = cur + 7'd1;
    end else begin
      if (cur == 7'h00)      v = 7'h4F;
      else if (cur == 7'h40) v = 7'h0F;
      else                   v = cur - 7'd1;
    end
    return v;
  endfunction

  // Shift all bus inputs through the synchronizer and remember the last enable
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      r_data_sync <= '0;
      r_rs_sync   <= '0;
      r_rw_sync   <= '0;
      r_en_sync   <= '0;
      r_en_last   <= 1'b0;
    end else begin
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.lcd_data_in};
      r_rs_sync   <= {r_rs_sync[SYNC_STAGES-2:0], bus.lcd_rs_in};
      r_rw_sync   <= {r_rw_sync[SYNC_STAGES-2:0], bus.lcd_rw_in};
      r_en_sync   <= {r_en_sync[SYNC_STAGES-2:0], bus.lcd_en_in};
      r_en_last   <= r_en_sync[SYNC_STAGES-1];
    end
  end

  assign w_data      = r_data_sync[SYNC_STAGES-1];
  assign w_rs        = r_rs_sync[SYNC_STAGES-1];
  assign w_rw        = r_rw_sync[SYNC_STAGES-1];
  assign w_strobe    = r_en_last & ~r_en_sync[SYNC_STAGES-1];
  assign w_accept    = w_strobe & ~w_rw & ~r_busy;
  assign w_violation = (w_strobe & (w_rw | r_busy)) | w_illegal;

  // Decode an accepted strobe into next controller state
  always_comb begin
    w_cursor_nxt = r_cursor;
    w_id_nxt     = r_id;
    w_cgram_nxt  = r_cgram;
    w_disp_nxt   = r_disp;
    w_long       = 1'b0;
    w_illegal    = 1'b0;
    w_clear      = 1'b0;
    w_wr_en      = 1'b0;
    if (w_accept) begin
      if (w_rs) begin
        // Characters sent in CGRAM mode are discarded but still acknowledged
        if (!r_cgram) begin
          w_wr_en      = 1'b1;
          w_cursor_nxt = f_step(r_cursor, r_id);
        end
      end else if (w_data[7]) begin
        // Only 0x00-0x0F and 0x40-0x4F exist on a 16x2 panel
        if (w_data[5:4] == 2'b00) begin
          w_cursor_nxt = w_data[6:0];
          w_cgram_nxt  = 1'b0;
        end else begin
          w_illegal = 1'b1;
        end
      end else if (w_data[6]) begin
        w_cgram_nxt = 1'b1;
      end else if (w_data[5]) begin
        // Function set: no modelled effect
        w_long = 1'b0;
      end else if (w_data[4]) begin
        if (!w_data[3]) w_cursor_nxt = f_step(r_cursor, w_data[2]);
      end else if (w_data[3]) begin
        w_disp_nxt = w_data[2];
      end else if (w_data[2]) begin
        w_id_nxt = w_data[1];
      end else if (w_data[1]) begin
        w_cursor_nxt = 7'h00;
        w_cgram_nxt  = 1'b0;
        w_long       = 1'b1;
      end else if (w_data[0]) begin
        w_clear      = 1'b1;
        w_cursor_nxt = 7'h00;
        w_id_nxt     = 1'b1;
        w_cgram_nxt  = 1'b0;
        w_long       = 1'b1;
      end
    end
  end

  // Controller state, busy window, pulses and sticky error flag
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      r_cursor <= 7'h00;
      r_id     <= 1'b1;
      r_cgram  <= 1'b0;
      r_disp   <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_cmd_v  <= 1'b0;
      r_char_v <= 1'b0;
      r_code   <= 8'h00;
      r_err    <= 1'b0;
    end else begin
      r_cursor <= w_cursor_nxt;
      r_id     <= w_id_nxt;
      r_cgram  <= w_cgram_nxt;
      r_disp   <= w_disp_nxt;
      r_cmd_v  <= w_accept & ~w_rs;
      r_char_v <= w_accept & w_rs;
      if (w_accept) r_code <= w_data;
      if (w_accept) begin
        r_busy <= 1'b1;
        r_cnt  <= w_long ? C_CLEAR_LD : C_BUSY_LD;
      end else if (r_busy) begin
        if (r_cnt == '0) r_busy <= 1'b0;
        else             r_cnt  <= r_cnt - 1'b1;
      end
      // A new violation wins over a simultaneous clear request
      if (w_violation)  r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  // DDRAM shadow: single-cycle bulk clear or one byte write
  always_ff @(posedge clk_50) begin
    if (!rst_n || w_clear) begin
      for (int i = 0; i < 32; i++) r_shadow[i] <= 8'h20;
    end else if (w_wr_en) begin
      r_shadow[{r_cursor[6], r_cursor[3:0]}] <= w_data;
    end
  end

  // Registered read port; a same-cycle write is seen one cycle later
  always_ff @(posedge clk_50) begin
    if (!rst_n) r_rd_data <= 8'h00;
    else        r_rd_data <= r_shadow[rd_addr];
  end

  assign rd_data      = r_rd_data;
  assign cursor_addr  = r_cursor;
  assign display_on   = r_disp;
  assign busy         = r_busy;
  assign cmd_valid    = r_cmd_v;
  assign char_valid   = r_char_v;
  assign code_out     = r_code;
  assign protocol_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_monitor.sv
// ============================================================================
// Module      : tb_lcd_bus_monitor
// Description : Directed self-checking bench for lcd_bus_monitor
//               (BUSY_CYCLES=20, CLEAR_CYCLES=100, SYNC_STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_bus_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       err_clr = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic [6:0] cursor_addr;
  logic       display_on, busy, cmd_valid, char_valid, protocol_err;
  logic [7:0] code_out;

  int tests_run = 0;
  int tests_failed = 0;
  int n_cmd = 0;
  int n_char = 0;

  lcd_bus_monitor_if bus_if();

  lcd_bus_monitor #(
    .SYNC_STAGES (2),
    .BUSY_CYCLES (20),
    .CLEAR_CYCLES(100)
  ) dut (
    .clk_50      (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .err_clr     (err_clr),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .cursor_addr (cursor_addr),
    .display_on  (display_on),
    .busy        (busy),
    .cmd_valid   (cmd_valid),
    .char_valid  (char_valid),
    .code_out    (code_out),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Count accept pulses away from the active edge
  always @(negedge clk) begin
    if (cmd_valid)  n_cmd++;
    if (char_valid) n_char++;
  end

  task automatic wr(input logic rs, input logic rw, input logic [7:0] d, input int gap);
    @(negedge clk);
    bus_if.lcd_data_in = d;
    bus_if.lcd_rs_in   = rs;
    bus_if.lcd_rw_in   = rw;
    bus_if.lcd_en_in   = 1'b1;
    repeat (2) @(negedge clk);
    bus_if.lcd_en_in   = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] v);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %0h expected 0", busy); end
    tests_run++; if (cursor_addr !== 7'h00) begin tests_failed++; $display("FAIL rst_cursor: got %0h expected 0", cursor_addr); end
    tests_run++; if (display_on !== 1'b0) begin tests_failed++; $display("FAIL rst_disp: got %0h expected 0", display_on); end
    tests_run++; if (protocol_err !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %0h expected 0", protocol_err); end
    tests_run++; if ({cmd_valid, char_valid} !== 2'b00) begin tests_failed++; $display("FAIL rst_pulses: got %0h expected 0", {cmd_valid, char_valid}); end
    tests_run++; if (code_out !== 8'h00) begin tests_failed++; $display("FAIL rst_code: got %0h expected 0", code_out); end
    tests_run++; if (rd_data !== 8'h00) begin tests_failed++; $display("FAIL rst_rd_data: got %0h expected 0", rd_data); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Pulse appears 3 cycles after en falls; busy lasts BUSY_CYCLES+1 cycles
  task automatic test_latency();
    @(negedge clk);
    bus_if.lcd_data_in = 8'h00;
    bus_if.lcd_rs_in   = 1'b0;
    bus_if.lcd_rw_in   = 1'b0;
    bus_if.lcd_en_in   = 1'b1;
    repeat (2) @(negedge clk);
    bus_if.lcd_en_in   = 1'b0;
    @(negedge clk);
    tests_run++; if (cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_early1: got %0h expected 0", cmd_valid); end
    @(negedge clk);
    tests_run++; if (cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_early2: got %0h expected 0", cmd_valid); end
    @(negedge clk);
    tests_run++; if (cmd_valid !== 1'b1) begin tests_failed++; $display("FAIL lat_pulse: got %0h expected 1", cmd_valid); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL lat_busy_start: got %0h expected 1", busy); end
    repeat (20) @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL lat_busy_last: got %0h expected 1", busy); end
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL lat_busy_end: got %0h expected 0", busy); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_init();
    int c0;
    logic [7:0] v;
    c0 = n_cmd;
    wr(1'b0, 1'b0, 8'h38, 120);
    wr(1'b0, 1'b0, 8'h0C, 120);
    wr(1'b0, 1'b0, 8'h06, 120);
    wr(1'b0, 1'b0, 8'h01, 120);
    tests_run++; if (n_cmd - c0 !== 4) begin tests_failed++; $display("FAIL t1_cmd_count: got %0d expected 4", n_cmd - c0); end
    tests_run++; if (display_on !== 1'b1) begin tests_failed++; $display("FAIL t1_disp: got %0h expected 1", display_on); end
    tests_run++; if (cursor_addr !== 7'h00) begin tests_failed++; $display("FAIL t1_cursor: got %0h expected 0", cursor_addr); end
    tests_run++; if (protocol_err !== 1'b0) begin tests_failed++; $display("FAIL t1_err: got %0h expected 0", protocol_err); end
    tests_run++; if (code_out !== 8'h01) begin tests_failed++; $display("FAIL t1_code: got %0h expected 01", code_out); end
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), v);
      tests_run++; if (v !== 8'h20) begin tests_failed++; $display("FAIL t1_blank[%0d]: got %0h expected 20", i, v); end
    end
  endtask

  task automatic test_text();
    string s;
    int    k0;
    logic [7:0] v;
    s  = "0123456789ABCDEF";
    k0 = n_char;
    for (int i = 0; i < 16; i++) wr(1'b1, 1'b0, s[i], 30);
    wr(1'b1, 1'b0, 8'h58, 30);
    tests_run++; if (n_char - k0 !== 17) begin tests_failed++; $display("FAIL t2_char_count: got %0d expected 17", n_char - k0); end
    for (int i = 0; i < 16; i++) begin
      rd(5'(i), v);
      tests_run++; if (v !== s[i]) begin tests_failed++; $display("FAIL t2_text[%0d]: got %0h expected %0h", i, v, s[i]); end
    end
    rd(5'd16, v);
    tests_run++; if (v !== 8'h58) begin tests_failed++; $display("FAIL t2_line1: got %0h expected 58", v); end
    tests_run++; if (cursor_addr !== 7'h41) begin tests_failed++; $display("FAIL t2_cursor: got %0h expected 41", cursor_addr); end
    tests_run++; if (code_out !== 8'h58) begin tests_failed++; $display("FAIL t2_code: got %0h expected 58", code_out); end
  endtask

  task automatic test_wrap_entry();
    logic [7:0] v;
    wr(1'b0, 1'b0, 8'hCF, 30);
    wr(1'b1, 1'b0, 8'h59, 30);
    wr(1'b1, 1'b0, 8'h5A, 30);
    rd(5'd31, v);
    tests_run++; if (v !== 8'h59) begin tests_failed++; $display("FAIL t3_sh31: got %0h expected 59", v); end
    rd(5'd0, v);
    tests_run++; if (v !== 8'h5A) begin tests_failed++; $display("FAIL t3_sh0: got %0h expected 5A", v); end
    tests_run++; if (cursor_addr !== 7'h01) begin tests_failed++; $display("FAIL t3_cursor1: got %0h expected 01", cursor_addr); end
    wr(1'b0, 1'b0, 8'h04, 30);
    wr(1'b1, 1'b0, 8'h51, 30);
    rd(5'd1, v);
    tests_run++; if (v !== 8'h51) begin tests_failed++; $display("FAIL t3_sh1: got %0h expected 51", v); end
    tests_run++; if (cursor_addr !== 7'h00) begin tests_failed++; $display("FAIL t3_cursor0: got %0h expected 00", cursor_addr); end
    tests_run++; if (protocol_err !== 1'b0) begin tests_failed++; $display("FAIL t3_err: got %0h expected 0", protocol_err); end
  endtask

  task automatic test_busy_violation();
    int k0;
    logic [7:0] v;
    wr(1'b0, 1'b0, 8'h00, 10);
    k0 = n_char;
    wr(1'b1, 1'b0, 8'h57, 40);
    tests_run++; if (n_char - k0 !== 0) begin tests_failed++; $display("FAIL t4_no_char: got %0d expected 0", n_char - k0); end
    rd(5'd0, v);
    tests_run++; if (v !== 8'h5A) begin tests_failed++; $display("FAIL t4_shadow: got %0h expected 5A", v); end
    tests_run++; if (cursor_addr !== 7'h00) begin tests_failed++; $display("FAIL t4_cursor: got %0h expected 00", cursor_addr); end
    tests_run++; if (protocol_err !== 1'b1) begin tests_failed++; $display("FAIL t4_err_set: got %0h expected 1", protocol_err); end
    pulse_err_clr();
    tests_run++; if (protocol_err !== 1'b0) begin tests_failed++; $display("FAIL t4_err_clr: got %0h expected 0", protocol_err); end
  endtask

  task automatic test_illegal();
    int c0, k0;
    c0 = n_cmd;
    wr(1'b0, 1'b0, 8'h95, 30);
    tests_run++; if (n_cmd - c0 !== 1) begin tests_failed++; $display("FAIL t5_cmd: got %0d expected 1", n_cmd - c0); end
    tests_run++; if (cursor_addr !== 7'h00) begin tests_failed++; $display("FAIL t5_cursor: got %0h expected 00", cursor_addr); end
    tests_run++; if (protocol_err !== 1'b1) begin tests_failed++; $display("FAIL t5_err_ddram: got %0h expected 1", protocol_err); end
    tests_run++; if (code_out !== 8'h95) begin tests_failed++; $display("FAIL t5_code: got %0h expected 95", code_out); end
    pulse_err_clr();
    c0 = n_cmd;
    k0 = n_char;
    wr(1'b0, 1'b1, 8'h55, 30);
    tests_run++; if ((n_cmd - c0) + (n_char - k0) !== 0) begin tests_failed++; $display("FAIL t5_rw_pulse: got %0d expected 0", (n_cmd - c0) + (n_char - k0)); end
    tests_run++; if (protocol_err !== 1'b1) begin tests_failed++; $display("FAIL t5_err_rw: got %0h expected 1", protocol_err); end
    pulse_err_clr();
  endtask

  task automatic test_shift_cgram();
    int k0;
    logic [7:0] v;
    wr(1'b0, 1'b0, 8'h14, 30);
    tests_run++; if (cursor_addr !== 7'h01) begin tests_failed++; $display("FAIL sh_right: got %0h expected 01", cursor_addr); end
    wr(1'b0, 1'b0, 8'h10, 30);
    tests_run++; if (cursor_addr !== 7'h00) begin tests_failed++; $display("FAIL sh_left: got %0h expected 00", cursor_addr); end
    wr(1'b0, 1'b0, 8'h10, 30);
    tests_run++; if (cursor_addr !== 7'h4F) begin tests_failed++; $display("FAIL sh_wrap: got %0h expected 4F", cursor_addr); end
    wr(1'b0, 1'b0, 8'h18, 30);
    tests_run++; if (cursor_addr !== 7'h4F) begin tests_failed++; $display("FAIL sh_display: got %0h expected 4F", cursor_addr); end
    wr(1'b0, 1'b0, 8'h08, 30);
    tests_run++; if (display_on !== 1'b0) begin tests_failed++; $display("FAIL disp_off: got %0h expected 0", display_on); end
    wr(1'b0, 1'b0, 8'h40, 30);
    k0 = n_char;
    wr(1'b1, 1'b0, 8'h4B, 30);
    tests_run++; if (n_char - k0 !== 1) begin tests_failed++; $display("FAIL cg_char: got %0d expected 1", n_char - k0); end
    tests_run++; if (cursor_addr !== 7'h4F) begin tests_failed++; $display("FAIL cg_cursor: got %0h expected 4F", cursor_addr); end
    rd(5'd31, v);
    tests_run++; if (v !== 8'h59) begin tests_failed++; $display("FAIL cg_shadow: got %0h expected 59", v); end
    wr(1'b0, 1'b0, 8'h80, 30);
    tests_run++; if (cursor_addr !== 7'h00) begin tests_failed++; $display("FAIL ddram_00: got %0h expected 00", cursor_addr); end
    tests_run++; if (protocol_err !== 1'b0) begin tests_failed++; $display("FAIL sh_err: got %0h expected 0", protocol_err); end
  endtask

  task automatic test_reset_midbusy();
    logic [7:0] v;
    wr(1'b0, 1'b0, 8'h06, 30);
    wr(1'b1, 1'b0, 8'h41, 30);
    rd(5'd0, v);
    tests_run++; if (v !== 8'h41) begin tests_failed++; $display("FAIL t6_write: got %0h expected 41", v); end
    wr(1'b0, 1'b0, 8'h01, 0);
    repeat (50) @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL t6_busy_before: got %0h expected 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL t6_busy: got %0h expected 0", busy); end
    tests_run++; if (cursor_addr !== 7'h00) begin tests_failed++; $display("FAIL t6_cursor: got %0h expected 00", cursor_addr); end
    rd(5'd0, v);
    tests_run++; if (v !== 8'h20) begin tests_failed++; $display("FAIL t6_blank: got %0h expected 20", v); end
  endtask

  initial begin
    bus_if.lcd_data_in = 8'h00;
    bus_if.lcd_rs_in   = 1'b0;
    bus_if.lcd_rw_in   = 1'b0;
    bus_if.lcd_en_in   = 1'b0;
    test_reset();
    test_latency();
    test_init();
    test_text();
    test_wrap_entry();
    test_busy_violation();
    test_illegal();
    test_shift_cgram();
    test_reset_midbusy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
